mult_datapath: RTL and testbench
================================

# mult_datapath

Shift-add multiplier datapath that sits directly downstream of the shift-add multiplier Moore controller. It consumes the controller's one-cycle strobes (load, add, shift, decrement, ready) and returns the two status bits the controller branches on: multiplier LSB and iteration-count-zero. It also buffers one operand pair on the input side and holds the finished product in an output register with a valid/ready handshake.

## Interface
- WIDTH, 8: operand width; product is 2*WIDTH.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high; clears all state.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  staging buffer empty; a transfer occurs when in_valid && in_ready.
- op_m  in  WIDTH  multiplicand.
- op_q  in  WIDTH  multiplier.
- load_regs  in  1  controller strobe: load the working registers.
- add_regs  in  1  controller strobe: {C,A} <= A + M.
- shift_regs  in  1  controller strobe: {C,A,Q} >>= 1.
- decre_p  in  1  controller strobe: P <= P - 1.
- ready  in  1  controller strobe: operation finished.
- pulso  out  1  Q[0] && busy && !zero; feeds the controller.
- zero  out  1  (P == 0) || !busy; feeds the controller.
- product  out  2*WIDTH  result register.
- out_valid  out  1  product valid; held until out_ready.
- out_ready  in  1  consumer accepts product.
- overrun  out  1  sticky; present only with MULT_DP_OVERRUN_EN.

## Operation
- **Registers:** M[WIDTH], A[WIDTH], C[1], Q[WIDTH], P[$clog2(WIDTH+1)], busy.
- **Staging buffer:** one entry. It fills on an in_valid && in_ready transfer. It empties when load_regs is accepted.
- **Strobe priority:** if more than one strobe is high in the same cycle, only the highest is acted on. Order is ready > load_regs > add_regs > shift_regs > decre_p.
- **load_regs:** accepted only when busy=0 and staging is full. It sets M=op_m, Q=op_q, A=0, C=0, P=WIDTH, busy=1. Otherwise it is ignored. The controller pulses load_regs every iteration, so ignoring it while busy is required behaviour.
- **add_regs:** acted on only when busy && P!=0. {C,A} <= A + M, carry kept in C (WIDTH+1-bit add).
- **shift_regs:** acted on only when busy. Logical right shift of {C,A,Q}: C<=0, A<={C,A[W-1:1]}, Q<={A[0],Q[W-1:1]}.
- **decre_p:** acted on only when busy && P!=0. P saturates at 0, never wraps.
- **ready:** acted on only when busy. It sets product<={A,Q}, out_valid=1, busy=0. Ignored when busy=0.
- **pulso forced 0 once zero=1:** this guarantees the controller exits via its (pulso==0 && zero==1) path.
- **Idle:** with busy=0, zero=1 and pulso=0, so the controller cycles Ready→Load→Shift→Decr→Ready harmlessly until an operand arrives.
- **Output handshake:** out_valid clears on out_valid && out_ready.
- **Result overwrite:** if ready is accepted while out_valid=1 and out_ready=0, product is overwritten and out_valid stays 1.
- **Reset values:** in_ready=1, pulso=0, zero=1, product=0, out_valid=0, overrun=0, busy=0, staging empty. M, A, C, Q and P are all 0.
- **Reset mid-operation:** the in-flight operation and staged operand are discarded. No product is emitted.

## Timing
- All state updates on the rising clk edge; pulso and zero are combinational from registers.
- **Input path:** in_ready falls the cycle after a transfer. It rises the cycle after load_regs is accepted, so the next pair can be staged during computation.
- **load_regs effect:** strobe at edge k gives pulso=op_q[0] and zero=0 in cycle k+1 (when WIDTH>0).
- **Latency:** per-bit iteration follows the controller.
  - Bit = 0: load, shift, decr = 3 cycles.
  - Bit = 1: load, add, shift, decr = 4 cycles.
  - Full operation is 3·WIDTH to 4·WIDTH cycles plus 1 ready cycle.
- **Result availability:** out_valid rises the edge the ready strobe is sampled; product is stable from that cycle.
- **Same-cycle consume and produce:** if out_ready drains the old result in the same cycle ready is accepted, the new product wins and out_valid stays 1.

## Configuration
- **MULT_DP_OVERRUN_EN defined:** overrun port exists. It is set when ready is accepted while out_valid && !out_ready. It stays sticky until rst.
- **MULT_DP_OVERRUN_EN undefined:** no overrun port, no overrun register. Overwrite is silent.

## Structure
- **Package mult_pkg:**
  - MULT_WIDTH_DEFAULT=8.
  - typedef for the strobe priority encoding, enum {STB_NONE, STB_READY, STB_LOAD, STB_ADD, STB_SHIFT, STB_DECR}.
  - Function computing the P width.
- **Sub-module mult_operand_buf:** one-entry valid/ready holding register for {op_m, op_q}, with a pop input driven by the accepted load_regs. The rest of the datapath stays flat in mult_datapath.

## Test plan
- WIDTH=8, op_m=13, op_q=11, strobes driven as the controller sequence → product=16'h008F, out_valid=1 after the ready strobe; pulso follows Q[0] each Load cycle.
- op_m=255, op_q=255 → product=16'hFE01; C carry exercised on every add.
- op_m=0xA5, op_q=0 → product=0; no add strobe has any effect; zero rises after exactly 8 decre_p.
- Two pairs back-to-back, 6×7 then 9×9, with out_ready=0:
  - in_ready re-rises after the first load.
  - Second result overwrites: product=16'h0051, out_valid=1.
  - overrun=1 only with MULT_DP_OVERRUN_EN.
- rst pulsed after 3 iterations of 200×3 → all outputs at reset values within the cycle, no out_valid. A following 2×3 gives product=6.
- load_regs and add_regs high together while idle with staging full → load only (A=0, P=8). Extra decre_p at P=0 → P stays 0, zero=1.

Source files
------------

// File: rtl/mult_pkg.sv
// mult_pkg: shared width default, strobe priority encoding and P-counter width helper
package mult_pkg;
  localparam int MULT_WIDTH_DEFAULT = 8;
  typedef enum logic [2:0] {STB_NONE, STB_READY, STB_LOAD, STB_ADD, STB_SHIFT, STB_DECR} stb_e;
  function automatic int p_width(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/mult_operand_buf.sv
// mult_operand_buf: one-entry operand staging (in_valid/in_ready/op_m/op_q in; pop in; full/buf_m/buf_q out)
module mult_operand_buf #(parameter int WIDTH = 8) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_m,
  input  logic [WIDTH-1:0] op_q,
  input  logic             pop,
  output logic             full,
  output logic [WIDTH-1:0] buf_m,
  output logic [WIDTH-1:0] buf_q
);
  assign in_ready = !full;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      full  <= 1'b0;
      buf_m <= '0;
      buf_q <= '0;
    end else if (in_valid && in_ready) begin
      full  <= 1'b1;
      buf_m <= op_m;
      buf_q <= op_q;
    end else if (pop) full <= 1'b0;
endmodule

// File: rtl/mult_datapath.sv
// mult_datapath: shift-add multiplier datapath (controller strobes in; pulso/zero out; staged operand input, valid/ready product output; sticky overrun port with MULT_DP_OVERRUN_EN)
module mult_datapath
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   op_m,
  input  logic [WIDTH-1:0]   op_q,
  input  logic               load_regs,
  input  logic               add_regs,
  input  logic               shift_regs,
  input  logic               decre_p,
  input  logic               ready,
  output logic               pulso,
  output logic               zero,
  output logic [2*WIDTH-1:0] product,
  output logic               out_valid,
`ifdef MULT_DP_OVERRUN_EN
  output logic               overrun,
`endif
  input  logic               out_ready
);
  localparam int PW = p_width(WIDTH);
  logic [WIDTH-1:0] m, a, q, buf_m, buf_q;
  logic [PW-1:0] p;
  logic c, busy, full, load_acc, ready_acc;
  stb_e stb;
  mult_operand_buf #(.WIDTH(WIDTH)) u_buf (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_m(op_m), .op_q(op_q), .pop(load_acc), .full(full), .buf_m(buf_m), .buf_q(buf_q)
  );
  assign stb = ready ? STB_READY : load_regs ? STB_LOAD : add_regs ? STB_ADD :
               shift_regs ? STB_SHIFT : decre_p ? STB_DECR : STB_NONE;
  assign load_acc  = (stb == STB_LOAD) && !busy && full;
  assign ready_acc = (stb == STB_READY) && busy;
  assign zero  = (p == '0) || !busy;
  assign pulso = q[0] && !zero;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      m         <= '0;
      a         <= '0;
      q         <= '0;
      c         <= 1'b0;
      p         <= '0;
      busy      <= 1'b0;
      product   <= '0;
      out_valid <= 1'b0;
    end else begin
      if (ready_acc) begin
        product <= {a, q};
        busy    <= 1'b0;
      end else if (load_acc) begin
        m    <= buf_m;
        q    <= buf_q;
        a    <= '0;
        c    <= 1'b0;
        p    <= PW'(WIDTH);
        busy <= 1'b1;
      end else if (stb == STB_ADD && !zero) {c, a} <= {1'b0, a} + {1'b0, m};
      else if (stb == STB_SHIFT && busy) {c, a, q} <= {1'b0, c, a, q[WIDTH-1:1]};
      else if (stb == STB_DECR && !zero) p <= p - PW'(1);
      out_valid <= ready_acc || (out_valid && !out_ready);
    end
`ifdef MULT_DP_OVERRUN_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) overrun <= 1'b0;
    else if (ready_acc && out_valid && !out_ready) overrun <= 1'b1;
`endif
endmodule

// File: tb/tb_mult_datapath.sv
// tb_mult_datapath: self-checking bench driving controller-style strobe sequences against an arithmetic product model
module tb_mult_datapath;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, in_ready;
  logic [W-1:0] op_m = '0, op_q = '0;
  logic load_regs = 1'b0, add_regs = 1'b0, shift_regs = 1'b0, decre_p = 1'b0, ready = 1'b0;
  logic pulso, zero, out_valid, out_ready = 1'b0;
  logic [2*W-1:0] product;
`ifdef MULT_DP_OVERRUN_EN
  logic overrun;
`endif
  int checks = 0, errors = 0;
  typedef struct {
    logic [W-1:0]   m;
    logic [W-1:0]   q;
    logic [2*W-1:0] exp;
  } vec_t;
  vec_t vecs[4];

  mult_datapath #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op_m(op_m), .op_q(op_q),
    .load_regs(load_regs), .add_regs(add_regs), .shift_regs(shift_regs), .decre_p(decre_p),
    .ready(ready), .pulso(pulso), .zero(zero), .product(product), .out_valid(out_valid),
`ifdef MULT_DP_OVERRUN_EN
    .overrun(overrun),
`endif
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] m, input logic [W-1:0] q);
    int n = 0;
    in_valid = 1'b1;
    op_m = m;
    op_q = q;
    while (!in_ready && n < 200) begin
      tick;
      n++;
    end
    if (!in_ready) chk("push_timeout", 32'(in_ready), 32'd1);
    tick;
    in_valid = 1'b0;
    chk("in_ready_fall", 32'(in_ready), 32'd0);
  endtask

  // Emulates the controller: Load, [Add], Shift, Decr per bit, Ready once zero is seen
  task automatic run_op(input logic [W-1:0] qv, input int stop_after, input bit do_check, input logic ord);
    int it = 0;
    load_regs = 1'b1;
    tick;
    load_regs = 1'b0;
    if (do_check) chk("in_ready_rise", 32'(in_ready), 32'd1);
    while (!zero) begin
      if (do_check) chk($sformatf("pulso_bit%0d", it), 32'(pulso), 32'(qv[it]));
      if (pulso) begin
        add_regs = 1'b1;
        tick;
        add_regs = 1'b0;
      end
      shift_regs = 1'b1;
      tick;
      shift_regs = 1'b0;
      decre_p = 1'b1;
      tick;
      decre_p = 1'b0;
      it++;
      if (it == stop_after) return;
      if (it > W + 2) begin
        chk("iter_timeout", it, W);
        return;
      end
      load_regs = 1'b1;
      tick;
      load_regs = 1'b0;
    end
    if (do_check) chk("iterations", it, W);
    ready = 1'b1;
    out_ready = ord;
    tick;
    ready = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic do_mult(input string name, input logic [W-1:0] m, input logic [W-1:0] q);
    logic [2*W-1:0] exp = (2*W)'(m) * (2*W)'(q);
    push(m, q);
    run_op(q, -1, 1'b1, 1'b0);
    chk({name, "_product"}, 32'(product), 32'(exp));
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk({name, "_drain"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    vecs[0] = '{8'd13, 8'd11, 16'h008F};
    vecs[1] = '{8'd255, 8'd255, 16'hFE01};
    vecs[2] = '{8'hA5, 8'd0, 16'h0000};
    vecs[3] = '{8'd2, 8'd3, 16'h0006};
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_pulso", 32'(pulso), 32'd0);
    chk("rst_zero", 32'(zero), 32'd1);
    chk("rst_product", 32'(product), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    tick;
    for (int i = 0; i < 4; i++) begin
      push(vecs[i].m, vecs[i].q);
      run_op(vecs[i].q, -1, 1'b1, 1'b0);
      chk($sformatf("vec%0d_product", i), 32'(product), 32'(vecs[i].exp));
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
    end
    add_regs = 1'b1;
    tick;
    add_regs = 1'b0;
    chk("idle_add_a", 32'(dut.a), 32'd0);
    chk("idle_add_product", 32'(product), 32'd6);
    for (int i = 0; i < 25; i++) do_mult($sformatf("rnd%0d", i), W'($urandom), W'($urandom));
    push(8'd6, 8'd7);
    run_op(8'd7, -1, 1'b1, 1'b0);
    chk("b2b_first", 32'(product), 32'd42);
    push(8'd9, 8'd9);
    run_op(8'd9, -1, 1'b1, 1'b0);
    chk("b2b_overwrite", 32'(product), 32'h51);
    chk("b2b_valid", 32'(out_valid), 32'd1);
`ifdef MULT_DP_OVERRUN_EN
    chk("overrun_set", 32'(overrun), 32'd1);
`endif
    push(8'd2, 8'd5);
    run_op(8'd5, -1, 1'b1, 1'b1);
    chk("same_cycle_product", 32'(product), 32'd10);
    chk("same_cycle_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    push(8'd200, 8'd3);
    run_op(8'd3, 3, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_pulso", 32'(pulso), 32'd0);
    chk("mid_rst_zero", 32'(zero), 32'd1);
    chk("mid_rst_product", 32'(product), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
`ifdef MULT_DP_OVERRUN_EN
    chk("mid_rst_overrun", 32'(overrun), 32'd0);
`endif
    tick;
    rst = 1'b0;
    tick;
    chk("post_rst_no_valid", 32'(out_valid), 32'd0);
    do_mult("post_rst", 8'd2, 8'd3);
    push(8'd5, 8'd4);
    load_regs = 1'b1;
    add_regs = 1'b1;
    tick;
    load_regs = 1'b0;
    add_regs = 1'b0;
    chk("ld_add_a", 32'(dut.a), 32'd0);
    chk("ld_add_p", 32'(dut.p), 32'd8);
    chk("ld_add_zero", 32'(zero), 32'd0);
    run_op(8'd4, -1, 1'b1, 1'b0);
    chk("ld_add_product", 32'(product), 32'd20);
    decre_p = 1'b1;
    tick;
    decre_p = 1'b0;
    chk("extra_decr_p", 32'(dut.p), 32'd0);
    chk("extra_decr_zero", 32'(zero), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
